// File: rtl/slice_packer.sv
// Packs DEPTH slices of WIDTH bits into one vector, little-endian by slice.
// Flush closes a partial vector early, padding the unfilled slices with PAD.
module slice_packer #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 48,
    parameter int PAD   = 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [WIDTH-1:0]               in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           flush,
    output logic [WIDTH*DEPTH-1:0]         out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [$clog2(DEPTH+1)-1:0]     word_count
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            word_count_q, word_count_d;
    logic [WIDTH*DEPTH-1:0]   out_data_q, out_data_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;

    logic                     accept;
    logic                     close;
    logic                     last;
    logic [CW-1:0]            pad_from;

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        out_data_d   = out_data_q;

        accept   = (state_q == FILL) && in_valid;
        // A flush with nothing stored and nothing arriving is a no-op.
        close    = (state_q == FILL) && flush
                   && (accept || (word_count_q != '0));
        last     = accept && (word_count_q == CW'(DEPTH - 1));
        pad_from = accept ? word_count_q + CW'(1) : word_count_q;

        for (int k = 0; k < DEPTH; k++) begin
            if (accept && (CW'(k) == word_count_q)) begin
                out_data_d[k*WIDTH +: WIDTH] = in_data;
            end else if (close && (CW'(k) >= pad_from)) begin
                out_data_d[k*WIDTH +: WIDTH] = WIDTH'(PAD);
            end
        end

        unique case (state_q)
            FILL: begin
                if (close || last) begin
                    state_d      = HOLD;
                    word_count_d = CW'(DEPTH);
                end else if (accept) begin
                    word_count_d = word_count_q + CW'(1);
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d      = FILL;
                    word_count_d = '0;
                end
            end
        endcase

        in_ready_d  = (state_d == FILL);
        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= FILL;
            word_count_q <= '0;
            out_data_q   <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            out_data_q   <= out_data_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_slice_packer.sv
// Bench for slice_packer: directed cases plus a random stream
// checked against a queue-based vector model.
module tb_slice_packer;

    localparam int W  = 10;
    localparam int D  = 48;
    localparam int P  = 1;
    localparam int CW = $clog2(D + 1);
    localparam int VW = W * D;

    logic          clk = 1'b0;
    logic          rstn;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic [VW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] word_count;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0]  m_words[$];
    logic          m_hold = 1'b0;
    logic [VW-1:0] m_vec  = '0;
    logic [VW-1:0] exp_v;

    slice_packer #(.WIDTH(W), .DEPTH(D), .PAD(P)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VW-1:0] got,
                       input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Spec-level model: a vector closes when full, or on a flush
    // once at least one word (stored or arriving) exists.
    task automatic model_edge(input logic v, input logic [W-1:0] d,
                              input logic f, input logic r);
        if (!m_hold) begin
            if (v) m_words.push_back(d);
            if (m_words.size() == D || (f && m_words.size() > 0)) begin
                for (int k = 0; k < D; k++)
                    m_vec[k*W +: W] = (k < m_words.size())
                                      ? m_words[k] : W'(P);
                m_hold = 1'b1;
            end
        end else if (r) begin
            m_hold = 1'b0;
            m_words.delete();
        end
    endtask

    task automatic compare_all();
        chk("in_ready", VW'(in_ready), VW'(!m_hold));
        chk("out_valid", VW'(out_valid), VW'(m_hold));
        chk("word_count", VW'(word_count),
            m_hold ? VW'(D) : VW'(m_words.size()));
        if (m_hold) chk("out_data", out_data, m_vec);
    endtask

    task automatic step(input logic v, input logic [W-1:0] d,
                        input logic f, input logic r);
        in_valid  = v;
        in_data   = d;
        flush     = f;
        out_ready = r;
        @(posedge clk);
        model_edge(v, d, f, r);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int nvec;
        int cyc;
        logic v, f, r;
        logic [W-1:0] d;
        logic [VW-1:0] snap;

        rstn = 1'b0;
        in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_data", out_data, '0);
        chk("rst_word_count", VW'(word_count), '0);
        chk("rst_in_ready", VW'(in_ready), VW'(1));
        chk("rst_out_valid", VW'(out_valid), '0);
        rstn = 1'b1;
        @(negedge clk);

        // 48 words 1..48, no downstream ready
        for (int i = 1; i <= D; i++) step(1'b1, W'(i), 1'b0, 1'b0);
        for (int k = 0; k < D; k++) exp_v[k*W +: W] = W'(k + 1);
        chk("full_vec", out_data, exp_v);
        chk("full_in_ready", VW'(in_ready), '0);
        chk("full_wc", VW'(word_count), VW'(D));
        step(1'b0, '0, 1'b0, 1'b1);

        // five 7s then flush alone
        for (int i = 0; i < 5; i++) step(1'b1, W'(7), 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < D; k++) exp_v[k*W +: W] = (k < 5) ? W'(7) : W'(1);
        chk("flush5_vec", out_data, exp_v);
        chk("flush5_valid", VW'(out_valid), VW'(1));
        step(1'b0, '0, 1'b0, 1'b1);

        // flush with first word at word_count 0
        step(1'b1, W'(10'h3FF), 1'b1, 1'b0);
        for (int k = 0; k < D; k++)
            exp_v[k*W +: W] = (k == 0) ? W'(10'h3FF) : W'(1);
        chk("flush1_vec", out_data, exp_v);
        chk("flush1_valid", VW'(out_valid), VW'(1));

        // stall in HOLD while in_valid toggles and flush is noise
        for (int i = 0; i < 10; i++)
            step(1'(i % 2), W'(i + 100), 1'(i % 3 == 0), 1'b0);
        chk("hold_vec", out_data, exp_v);
        chk("hold_wc", VW'(word_count), VW'(D));
        step(1'b0, '0, 1'b0, 1'b1);
        chk("release_wc", VW'(word_count), '0);
        chk("release_in_ready", VW'(in_ready), VW'(1));

        // flush alone at word_count 0 is ignored
        step(1'b0, '0, 1'b1, 1'b0);
        chk("flush0_wc", VW'(word_count), '0);
        chk("flush0_valid", VW'(out_valid), '0);

        // asynchronous reset after 20 accepts
        for (int i = 0; i < 20; i++) step(1'b1, W'(500 + i), 1'b0, 1'b0);
        #2 rstn = 1'b0;
        #1;
        chk("arst_out_data", out_data, '0);
        chk("arst_wc", VW'(word_count), '0);
        chk("arst_in_ready", VW'(in_ready), VW'(1));
        m_hold = 1'b0;
        m_words.delete();
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < D; i++) step(1'b1, W'(200 + 3 * i), 1'b0, 1'b0);
        for (int k = 0; k < D; k++) exp_v[k*W +: W] = W'(200 + 3 * k);
        chk("fresh_vec", out_data, exp_v);
        snap = exp_v;
        step(1'b0, '0, 1'b0, 1'b1);
        chk("fresh_keep", out_data, snap);

        // random stream
        nvec = 0;
        cyc  = 0;
        while (nvec < 1000 && cyc < 60000) begin
            v = ($urandom_range(0, 99) < 85);
            f = ($urandom_range(0, 31) == 0);
            r = 1'($urandom_range(0, 1));
            d = W'($urandom);
            if (m_hold && r) nvec++;
            step(v, d, f, r);
            cyc++;
        end
        chk("vec_budget", VW'(nvec), VW'(1000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
